// File: rtl/keyed_pipe_adder_if.sv
// Handshake and operand bundle for keyed_pipe_adder: input side (valid/ready,
// operands, mode) and output side (valid/ready, result).
interface keyed_pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/keyed_pipe_adder.sv
// Key-obfuscated adder/subtractor pipelined over STAGE_W-bit carry stages,
// one stage per clock, with valid/ready flow control and full backpressure.
module keyed_pipe_adder #(
    parameter int WIDTH   = 8,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load_i,
    input  logic [WIDTH-1:0] key_in_i,
    keyed_pipe_adder_if.slave bus
);
    localparam int NSTAGES = WIDTH / STAGE_W;

    logic [WIDTH-1:0] key_d, key_q;
    logic [WIDTH-1:0] encA, bEff;
    logic             c0;
    logic             adv;

    assign adv          = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = adv;

    // Key is only sampled at acceptance, so a same-cycle load is seen by the next input.
    assign encA = bus.a ^ key_q;
    assign bEff = bus.sub ? ~bus.b : bus.b;
    assign c0   = bus.sub | bus.cin;

    always_comb begin
        key_d = key_q;
        if (key_load_i) begin
            key_d = key_in_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    for (genvar i = 0; i < NSTAGES; i++) begin : stg
        localparam int REMW = WIDTH - i * STAGE_W;

        logic [REMW-1:0]    opA, opB;
        logic               cIn, vIn;
        logic [WIDTH-1:0]   sumIn;
        logic [STAGE_W:0]   part;
        logic               valid_d, valid_q;
        logic               carry_d, carry_q;
        logic [WIDTH-1:0]   sum_d, sum_q;

        if (i == 0) begin : g_src
            assign opA   = encA;
            assign opB   = bEff;
            assign cIn   = c0;
            assign vIn   = bus.in_valid;
            assign sumIn = '0;
        end else begin : g_src
            assign opA   = stg[i-1].g_rem.aRem_q;
            assign opB   = stg[i-1].g_rem.bRem_q;
            assign cIn   = stg[i-1].carry_q;
            assign vIn   = stg[i-1].valid_q;
            assign sumIn = stg[i-1].sum_q;
        end

        // Lower slices already resolved arrive in sumIn; this stage ORs its slice in.
        assign part    = {1'b0, opA[STAGE_W-1:0]} + {1'b0, opB[STAGE_W-1:0]}
                       + {{STAGE_W{1'b0}}, cIn};
        assign valid_d = vIn;
        assign carry_d = part[STAGE_W];
        assign sum_d   = sumIn | (WIDTH'(part[STAGE_W-1:0]) << (i * STAGE_W));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (i < NSTAGES - 1) begin : g_rem
            logic [REMW-STAGE_W-1:0] aRem_q, bRem_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    aRem_q <= '0;
                    bRem_q <= '0;
                end else if (adv) begin
                    aRem_q <= opA[REMW-1:STAGE_W];
                    bRem_q <= opB[REMW-1:STAGE_W];
                end
            end
        end
    end

    assign bus.out_valid = stg[NSTAGES-1].valid_q;
    assign bus.sum       = {stg[NSTAGES-1].carry_q, stg[NSTAGES-1].sum_q};
    assign bus.cout      = stg[NSTAGES-1].carry_q;

endmodule

// File: tb/tb_keyed_pipe_adder.sv
// Directed self-checking bench for keyed_pipe_adder (WIDTH=8, STAGE_W=4):
// vector table, backpressure stream, same-cycle key load and mid-flight reset.
module tb_keyed_pipe_adder;
    logic       clk;
    logic       rst_n;
    logic       keyLoad;
    logic [7:0] keyIn;
    int         testsRun;
    int         testsFailed;

    keyed_pipe_adder_if #(.WIDTH(8)) busIf ();

    keyed_pipe_adder #(.WIDTH(8), .STAGE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load_i (keyLoad),
        .key_in_i   (keyIn),
        .bus        (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] key;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [8:0] expSum;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
        busIf.in_valid = 1'b1;
        busIf.a        = a;
        busIf.b        = b;
        busIf.cin      = cin;
        busIf.sub      = sub;
    endtask

    task automatic loadKey(input logic [7:0] k);
        @(negedge clk);
        keyLoad = 1'b1;
        keyIn   = k;
        @(negedge clk);
        keyLoad = 1'b0;
    endtask

    // Single transaction into an empty pipe; checks result and 2-cycle latency.
    task automatic runVector(input vec_t v, input bit doLoad, input string tag);
        int lat;
        bit seen;
        if (doLoad) loadKey(v.key);
        @(negedge clk);
        applyStimulus(v.a, v.b, v.cin, v.sub);
        lat  = 0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            busIf.in_valid = 1'b0;
            lat++;
            if (busIf.out_valid) seen = 1'b1;
        end
        checkOutput({tag, ".seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, ".sum"}, 32'(busIf.sum), 32'(v.expSum));
            checkOutput({tag, ".cout"}, 32'(busIf.cout), 32'(v.expSum[8]));
            checkOutput({tag, ".latency"}, 32'(lat), 32'd2);
        end
        @(negedge clk);
    endtask

    vec_t vecs[10];
    logic [8:0] expQ[$];
    logic [8:0] gotR[$];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int recv;
        int stale;
        bit accepted;

        testsRun    = 0;
        testsFailed = 0;

        vecs[0] = '{8'hAA, 8'hAE, 8'h93, 1'b0, 1'b0, 9'h097};
        vecs[1] = '{8'hAA, 8'hAE, 8'h93, 1'b0, 1'b1, 9'h071};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b0, 1'b0, 9'h100};
        vecs[3] = '{8'h00, 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010};
        vecs[4] = '{8'h00, 8'h0F, 8'h00, 1'b1, 1'b0, 9'h010};
        vecs[5] = '{8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 9'h100};
        vecs[6] = '{8'h00, 8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE};
        vecs[7] = '{8'h00, 8'h07, 8'h05, 1'b0, 1'b1, 9'h102};
        vecs[8] = '{8'h55, 8'h55, 8'h00, 1'b1, 1'b1, 9'h100};
        vecs[9] = '{8'hFF, 8'h0F, 8'h10, 1'b1, 1'b0, 9'h101};

        rst_n           = 1'b0;
        keyLoad         = 1'b0;
        keyIn           = 8'h00;
        busIf.in_valid  = 1'b0;
        busIf.a         = 8'h00;
        busIf.b         = 8'h00;
        busIf.cin       = 1'b0;
        busIf.sub       = 1'b0;
        busIf.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset.out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("reset.sum", 32'(busIf.sum), 32'd0);
        checkOutput("reset.cout", 32'(busIf.cout), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset.in_ready", 32'(busIf.in_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            runVector(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Six back-to-back inputs with the consumer stalled for three cycles.
        loadKey(8'h00);
        sent = 0;
        recv = 0;
        for (int i = 0; i < 6; i++) expQ.push_back(9'(8'h10 + 8'(i)) + 9'(i));
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            busIf.out_ready = !(c >= 3 && c <= 5);
            if (sent < 6) applyStimulus(8'(8'h10 + sent), 8'(sent), 1'b0, 1'b0);
            else          busIf.in_valid = 1'b0;
            #1;
            if (c >= 3 && c <= 5) begin
                checkOutput($sformatf("stall%0d.in_ready", c), 32'(busIf.in_ready), 32'd0);
                checkOutput($sformatf("stall%0d.out_valid", c), 32'(busIf.out_valid), 32'd1);
                checkOutput($sformatf("stall%0d.sumHeld", c), 32'(busIf.sum), 32'(expQ[0]));
            end
            accepted = busIf.in_valid && busIf.in_ready;
            if (busIf.out_valid && busIf.out_ready) begin
                checkOutput($sformatf("stream%0d.sum", recv), 32'(busIf.sum), 32'(expQ[0]));
                void'(expQ.pop_front());
                recv++;
            end
            if (accepted) sent++;
        end
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b1;
        checkOutput("stream.received", 32'(recv), 32'd6);
        stale = 0;
        repeat (3) begin
            @(negedge clk);
            if (busIf.out_valid) stale++;
        end
        checkOutput("stream.noDuplicate", 32'(stale), 32'd0);

        // Key changes in the same cycle an input is accepted.
        @(negedge clk);
        keyLoad = 1'b1;
        keyIn   = 8'hFF;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        keyLoad = 1'b0;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 10 && gotR.size() < 2; k++) begin
            @(negedge clk);
            busIf.in_valid = 1'b0;
            if (busIf.out_valid) gotR.push_back(busIf.sum);
        end
        checkOutput("keySwap.count", 32'(gotR.size()), 32'd2);
        if (gotR.size() == 2) begin
            checkOutput("keySwap.oldKey", 32'(gotR[0]), 32'h000);
            checkOutput("keySwap.newKey", 32'(gotR[1]), 32'h0FF);
        end
        @(negedge clk);

        // Reset with two transactions in flight.
        loadKey(8'h33);
        @(negedge clk);
        applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(8'h02, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        checkOutput("preReset.out_valid", 32'(busIf.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("midReset.sum", 32'(busIf.sum), 32'd0);
        checkOutput("midReset.cout", 32'(busIf.cout), 32'd0);
        checkOutput("midReset.in_ready", 32'(busIf.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (4) begin
            @(negedge clk);
            if (busIf.out_valid) stale++;
        end
        checkOutput("postReset.noStale", 32'(stale), 32'd0);
        runVector('{8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 9'h05A}, 1'b0, "postReset.keyCleared");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/keyed_pipe_adder.md
# keyed_pipe_adder

Parametrised, pipelined successor to the team's 8-bit key-locked ripple adder. Operand A is XOR-obfuscated with a loadable key register, then added to (or subtracted from) operand B across a chain of STAGE_W-bit carry stages, one stage per clock. A valid/ready handshake on both sides gives one result per cycle with full backpressure. It sits between the key oracle path and downstream consumers in the locked-datapath experiments.

## Interface
- WIDTH, 8: operand width; must be a multiple of STAGE_W.
- STAGE_W, 4: bits resolved per pipeline stage; NSTAGES = WIDTH/STAGE_W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_load  in  1  writes key_in into the key register.
- key_in  in  WIDTH  new key value.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept input this cycle.
- a  in  WIDTH  operand A; obfuscated as a ^ key on acceptance.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: enc_a + b + cin; 1: enc_a + ~b + 1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH+1  result; sum[WIDTH] is the final carry.
- cout  out  1  always equal to sum[WIDTH].

## Operation
- Key register: reset 0; on a clk edge with key_load=1 it takes key_in. The key is applied only at input acceptance, so in-flight transactions keep the key in force when they were accepted.
- Acceptance: in_valid & in_ready at a rising edge.
  - Stage 0 captures enc_a = a ^ key, b_eff = sub ? ~b : b, and c0 = sub ? 1 : cin.
  - key_load in the same cycle: the accepted input uses the old key.
- Stage i (0..NSTAGES-1):
  - Adds slice [i*STAGE_W +: STAGE_W] of enc_a and b_eff plus the incoming carry, as a STAGE_W-bit ripple.
  - Registers the partial sum, the carry out, and the not-yet-added upper operand slices.
  - Each stage carries its own valid bit.
- Last stage drives sum[WIDTH-1:0], sum[WIDTH] and cout. Subtract result: carry 1 means no borrow.
- Arithmetic is modulo 2^WIDTH plus carry bit; no saturation, no overflow flag.
- Stall: adv = !(out_valid & !out_ready).
  - When adv=0, every stage register and valid bit holds, and in_ready=0.
  - When adv=1, all stages shift together and in_ready=1.
  - Bubbles are not compressed.
- Reset (asynchronous, any time, including mid-operation): all valid bits 0, key 0, stage data 0, sum 0, cout 0, out_valid 0. In-flight transactions are discarded. in_ready is 1 once rst_n deasserts.

## Timing
- Latency: an input accepted at edge T gives out_valid=1 with its result after edge T+NSTAGES-1, i.e. it is visible in the cycle following edge T+NSTAGES-1. WIDTH=8, STAGE_W=4: visible 2 cycles after acceptance.
- Throughput: 1 transaction/cycle while out_ready=1.
- A result transfers at an edge where out_valid & out_ready. A new result may present in the same cycle.
- in_ready is combinational from out_valid and out_ready. No combinational path from in_valid to out_valid.
- sum/cout are stable while out_valid=1 and out_ready=0.
- NSTAGES=1 is legal: one-cycle latency, same handshake.

## Test plan
- WIDTH=8, STAGE_W=4, key=0xAA, a=174, b=147, cin=0, sub=0 -> sum=9'h097, cout=0, out_valid 2 cycles after accept.
- Same key and operands with sub=1 -> sum=9'h071 (0x04-0x93, carry 0 = borrow), cout=0.
- key=0, a=0xFF, b=0x01, cin=0 -> sum=9'h100, cout=1. Checks carry crossing the stage boundary. Also a=0x0F, b=0x01 -> 9'h010.
- Stream 6 back-to-back inputs, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, no results lost or duplicated, order preserved, sum held stable.
- key_load key 0x00 -> 0xFF in the cycle an input is accepted, next input a=0x00, b=0x00 -> first result uses the old key (0x000), second gives 0x0FF.
- Assert rst_n=0 with 2 transactions in flight -> outputs immediately 0, no stale result after release, key reads back as 0 (a=0x5A, b=0 -> 0x05A).
